// File: rtl/sha256_pio_pkg.sv
// Shared definitions for the SHA-256 PIO loader: FSM state encoding,
// control-register bit positions, status-word field layout and block sizes.
package sha256_pio_pkg;

  localparam int unsigned WORDS_PER_BLK = 16;
  localparam int unsigned DIGEST_WORDS  = 8;
  localparam int unsigned BUF_IDX_W     = 4;

  // State values double as the status-word state field.
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SEND = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  // pio_ctrl bit positions
  localparam int unsigned CTRL_TOG     = 0;
  localparam int unsigned CTRL_FIRST   = 1;
  localparam int unsigned CTRL_CLR     = 2;
  localparam int unsigned CTRL_SEL_LSB = 4;   // [6:4] word index, [7] forces zero
  localparam int unsigned CTRL_SEL_ZERO = 7;
  localparam int unsigned CTRL_MODE    = 8;

  // Status word layout
  localparam int unsigned STAT_CNT_LSB    = 0;
  localparam int unsigned STAT_CNT_W      = 5;
  localparam int unsigned STAT_STATE_LSB  = 5;
  localparam int unsigned STAT_STATE_W    = 2;
  localparam int unsigned STAT_DONE       = 7;
  localparam int unsigned STAT_OVF        = 8;
  localparam int unsigned STAT_BLKCNT_LSB = 16;
  localparam int unsigned STAT_BLKCNT_W   = 16;

endpackage

// File: rtl/sha256_blk_buf.sv
// 16 x 32-bit message block register file.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears all words)
//   we, idx, wdata  : write enable, word index (0..15), word to store
//   data            : whole block, word 0 in [511:480]
module sha256_blk_buf
  import sha256_pio_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [BUF_IDX_W-1:0] idx,
  input  logic [31:0]          wdata,
  output logic [511:0]         data
);

  logic [31:0] mem [WORDS_PER_BLK];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < WORDS_PER_BLK; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  always_comb begin
    data = '0;
    for (int unsigned i = 0; i < WORDS_PER_BLK; i++) begin
      data[511 - 32*i -: 32] = mem[i];
    end
  end

endmodule

// File: rtl/sha256_pio_loader.sv
// Bridges HPS PIO registers to a SHA-256 compression core: gathers 16 message
// words paced by a toggle bit, presents the 512-bit block over valid/ready,
// captures the digest and returns status or a digest word for read-back.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   pio_data          : message word from the data PIO
//   pio_ctrl          : [0] toggle, [1] first, [2] soft clear, [7:4] select, [8] read mode
//   blk_valid/ready   : block handshake to the core
//   blk_data          : 512-bit block, word 0 in [511:480]
//   blk_first         : core loads initial H values (qualified by blk_valid)
//   digest_valid      : one-cycle digest pulse from the core
//   digest            : 256-bit digest, H0 in [255:224]
//   rd_word           : registered status/digest word for the read PIO
module sha256_pio_loader
  import sha256_pio_pkg::*;
#(
  parameter int unsigned WORDS = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pio_data,
  input  logic [31:0]  pio_ctrl,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  input  logic         digest_valid,
  input  logic [255:0] digest,
  output logic [31:0]  rd_word
);

  state_t               state;
  logic [BUF_IDX_W-1:0] cnt;
  logic                 tog_q;
  logic                 first_q;
  logic                 done;
  logic                 ovf;
  logic [CNT_W-1:0]     blk_cnt;
  logic [31:0]          dig_q [DIGEST_WORDS];

  logic        word_ev;
  logic        clr;
  logic        buf_we;
  logic [31:0] status;
  logic [31:0] rd_next;
  logic        unused_ctrl;

  always_comb begin
    word_ev     = pio_ctrl[CTRL_TOG] ^ tog_q;
    clr         = pio_ctrl[CTRL_CLR];
    // Only FILL stores words; a clear cycle swallows any coincident toggle.
    buf_we      = word_ev && !clr && (state == ST_FILL);
    unused_ctrl = ^{pio_ctrl[31:9], pio_ctrl[3]};
  end

  sha256_blk_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .we    (buf_we),
    .idx   (cnt),
    .wdata (pio_data),
    .data  (blk_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FILL;
      cnt       <= '0;
      tog_q     <= 1'b0;
      first_q   <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      blk_cnt   <= '0;
      blk_valid <= 1'b0;
      blk_first <= 1'b0;
      for (int unsigned i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
    end else begin
      tog_q <= pio_ctrl[CTRL_TOG];
      if (clr) begin
        state     <= ST_FILL;
        cnt       <= '0;
        done      <= 1'b0;
        ovf       <= 1'b0;
        blk_valid <= 1'b0;
        blk_first <= 1'b0;
        for (int unsigned i = 0; i < DIGEST_WORDS; i++) dig_q[i] <= '0;
      end else begin
        case (state)
          ST_FILL: begin
            if (word_ev) begin
              if (cnt == '0) begin
                first_q <= pio_ctrl[CTRL_FIRST];
                done    <= 1'b0;
              end
              if (cnt == BUF_IDX_W'(WORDS - 1)) begin
                cnt       <= '0;
                state     <= ST_SEND;
                blk_valid <= 1'b1;
                blk_first <= first_q;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_SEND: begin
            if (word_ev) ovf <= 1'b1;
            if (blk_ready) begin
              state     <= ST_BUSY;
              blk_valid <= 1'b0;
              blk_first <= 1'b0;
            end
          end
          ST_BUSY: begin
            if (word_ev) ovf <= 1'b1;
            if (digest_valid) begin
              for (int unsigned i = 0; i < DIGEST_WORDS; i++) begin
                dig_q[i] <= digest[255 - 32*i -: 32];
              end
              done    <= 1'b1;
              blk_cnt <= blk_cnt + 1'b1;
              state   <= ST_FILL;
            end
          end
          default: state <= ST_FILL;
        endcase
      end
    end
  end

  always_comb begin
    status = '0;
    status[STAT_CNT_LSB +: STAT_CNT_W]       = STAT_CNT_W'(cnt);
    status[STAT_STATE_LSB +: STAT_STATE_W]   = state;
    status[STAT_DONE]                        = done;
    status[STAT_OVF]                         = ovf;
    status[STAT_BLKCNT_LSB +: STAT_BLKCNT_W] = STAT_BLKCNT_W'(blk_cnt);

    rd_next = status;
    if (pio_ctrl[CTRL_MODE]) begin
      rd_next = pio_ctrl[CTRL_SEL_ZERO] ? '0 : dig_q[pio_ctrl[CTRL_SEL_LSB +: 3]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_word <= '0;
    else       rd_word <= rd_next;
  end

endmodule

// File: tb/tb_sha256_pio_loader.sv
// Randomized self-checking bench for sha256_pio_loader with a transaction-level
// reference model (word queue, phase number, counters) plus literal checks.
module tb_sha256_pio_loader;

  localparam int unsigned TB_CNT_W = 4;  // small counter so wrap is reachable quickly

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pio_data;
  logic [31:0]  pio_ctrl;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         digest_valid;
  logic [255:0] digest;
  logic [31:0]  rd_word;

  int checks = 0;
  int errors = 0;

  sha256_pio_loader #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .pio_data     (pio_data),
    .pio_ctrl     (pio_ctrl),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .blk_first    (blk_first),
    .digest_valid (digest_valid),
    .digest       (digest),
    .rd_word      (rd_word)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_fill [$];
  logic [31:0] m_blk  [16];
  logic [31:0] m_dig  [8];
  int          m_phase;      // 0 collecting, 1 offering block, 2 waiting digest
  bit          m_first, m_done, m_ovf, m_prev, m_init;
  int          m_blkcnt;
  logic [31:0] m_rd;

  function automatic logic [31:0] m_read(input logic [31:0] ctrl);
    int sel;
    if (ctrl[8]) begin
      sel = int'(ctrl[7:4]);
      return (sel >= 8) ? 32'h0 : m_dig[sel];
    end
    return 32'(m_fill.size() + m_phase * 32 + int'(m_done) * 128 +
               int'(m_ovf) * 256 + m_blkcnt * 65536);
  endfunction

  function automatic logic [511:0] exp_block();
    logic [511:0] e = '0;
    for (int i = 0; i < 16; i++) e = (e << 32) | 512'(m_blk[i]);
    return e;
  endfunction

  always @(posedge clk) begin
    bit ev;
    m_init = 1'b1;
    if (reset) begin
      m_fill.delete();
      m_phase = 0; m_first = 0; m_done = 0; m_ovf = 0; m_prev = 0;
      m_blkcnt = 0; m_rd = '0;
      for (int i = 0; i < 8; i++) m_dig[i] = '0;
    end else begin
      m_rd   = m_read(pio_ctrl);
      ev     = pio_ctrl[0] != m_prev;
      m_prev = pio_ctrl[0];
      if (pio_ctrl[2]) begin
        m_fill.delete();
        m_phase = 0; m_done = 0; m_ovf = 0;
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
      end else if (m_phase == 0) begin
        if (ev) begin
          if (m_fill.size() == 0) begin m_first = pio_ctrl[1]; m_done = 0; end
          m_fill.push_back(pio_data);
          if (m_fill.size() == 16) begin
            for (int i = 0; i < 16; i++) m_blk[i] = m_fill[i];
            m_fill.delete();
            m_phase = 1;
          end
        end
      end else if (m_phase == 1) begin
        if (ev) m_ovf = 1;
        if (blk_ready) m_phase = 2;
      end else begin
        if (ev) m_ovf = 1;
        if (digest_valid) begin
          for (int i = 0; i < 8; i++) m_dig[i] = digest[255 - 32*i -: 32];
          m_done = 1;
          m_blkcnt = (m_blkcnt + 1) % (1 << TB_CNT_W);
          m_phase = 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      chk("blk_valid", 512'(blk_valid), 512'(m_phase == 1));
      chk("rd_word", 512'(rd_word), 512'(m_rd));
      if (m_phase == 1) begin
        chk("blk_data", blk_data, exp_block());
        chk("blk_first", 512'(blk_first), 512'(m_first));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic put_word(input logic [31:0] w, input bit first);
    @(negedge clk);
    pio_data    = w;
    pio_ctrl[1] = first;
    pio_ctrl[0] = ~pio_ctrl[0];
  endtask

  task automatic send_words(input int n, input bit first, input bit seq, input bit gaps);
    for (int i = 0; i < n; i++) begin
      put_word(seq ? 32'(i) : $urandom, first);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic accept(input bit rnd_delay);
    int n = 0;
    while (blk_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL accept_timeout: blk_valid never rose within %0d cycles", n);
    end
    if (rnd_delay) repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk); blk_ready = 1'b1;
    @(negedge clk); blk_ready = 1'b0;
  endtask

  task automatic finish_block(input logic [255:0] d);
    repeat ($urandom_range(1, 3)) begin @(negedge clk); blk_ready = 1'($urandom_range(0, 1)); end
    @(negedge clk); blk_ready = 1'b0; digest_valid = 1'b1; digest = d;
    @(negedge clk); digest_valid = 1'b0;
  endtask

  task automatic read_rd(input bit mode, input logic [3:0] sel, output logic [31:0] v);
    @(negedge clk); pio_ctrl[8] = mode; pio_ctrl[7:4] = sel;
    @(negedge clk);
    @(negedge clk); v = rd_word;
  endtask

  function automatic logic [255:0] rand_digest();
    logic [255:0] d = '0;
    for (int k = 0; k < 8; k++) d = {d[223:0], 32'($urandom)};
    return d;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] s;
    reset = 1'b1; pio_data = '0; pio_ctrl = '0; blk_ready = 1'b0;
    digest_valid = 1'b0; digest = '0;
    repeat (3) @(negedge clk);
    chk("reset_blk_valid", 512'(blk_valid), 512'(0));
    chk("reset_blk_first", 512'(blk_first), 512'(0));
    chk("reset_blk_data", blk_data, 512'(0));
    chk("reset_rd_word", 512'(rd_word), 512'(0));
    reset = 1'b0;

    // 16 sequential words, first block
    send_words(16, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_valid", 512'(blk_valid), 512'(1));
    chk("t1_word0", 512'(blk_data[511:480]), 512'(0));
    chk("t1_word15", 512'(blk_data[31:0]), 512'(32'hF));
    chk("t1_first", 512'(blk_first), 512'(1));

    // hold off ready, then accept
    repeat (5) @(negedge clk);
    accept(1'b0);
    chk("t2_valid_low", 512'(blk_valid), 512'(0));
    read_rd(1'b0, 4'd0, s);
    chk("t2_state_busy", 512'(s[6:5]), 512'(2));

    // digest capture and read-back
    finish_block({8{32'hA5A5A5A5}});
    read_rd(1'b1, 4'd3, s);
    chk("t3_digest_w3", 512'(s), 512'(32'hA5A5A5A5));
    read_rd(1'b0, 4'd0, s);
    chk("t3_done", 512'(s[7]), 512'(1));
    chk("t3_blkcnt", 512'(s[31:16]), 512'(1));

    // toggle during BUSY
    send_words(16, 1'b0, 1'b0, 1'b1);
    accept(1'b1);
    put_word(32'hDEADBEEF, 1'b0);
    read_rd(1'b0, 4'd0, s);
    chk("t4_ovf", 512'(s[8]), 512'(1));
    chk("t4_cnt", 512'(s[4:0]), 512'(0));
    finish_block(rand_digest());
    send_words(15, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("t4_not_valid_15", 512'(blk_valid), 512'(0));
    put_word($urandom, 1'b0);
    @(negedge clk);
    chk("t4_valid_16", 512'(blk_valid), 512'(1));
    accept(1'b1);
    finish_block(rand_digest());

    // soft clear after 7 words
    send_words(7, 1'b1, 1'b0, 1'b1);
    @(negedge clk); pio_ctrl[2] = 1'b1;
    @(negedge clk); pio_ctrl[2] = 1'b0;
    read_rd(1'b0, 4'd0, s);
    chk("t5_cnt", 512'(s[4:0]), 512'(0));
    chk("t5_done", 512'(s[7]), 512'(0));
    chk("t5_ovf", 512'(s[8]), 512'(0));
    chk("t5_blkcnt", 512'(s[31:16]), 512'(3));
    read_rd(1'b1, 4'd0, s);
    chk("t5_digest_zero", 512'(s), 512'(0));

    // soft clear during SEND
    send_words(16, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk); pio_ctrl[2] = 1'b1;
    @(negedge clk);
    chk("t5_clr_send", 512'(blk_valid), 512'(0));
    pio_ctrl[2] = 1'b0;

    // clear and toggle together, stray digest pulse in FILL
    @(negedge clk); pio_ctrl[2] = 1'b1; pio_ctrl[0] = ~pio_ctrl[0];
    @(negedge clk); pio_ctrl[2] = 1'b0;
    @(negedge clk); digest_valid = 1'b1; digest = rand_digest();
    @(negedge clk); digest_valid = 1'b0;
    read_rd(1'b0, 4'd0, s);
    chk("t6_cnt", 512'(s[4:0]), 512'(0));
    chk("t6_ovf", 512'(s[8]), 512'(0));
    chk("t6_done", 512'(s[7]), 512'(0));

    // run blocks until the counter wraps (3 -> 16 == 0)
    for (int b = 0; b < 13; b++) begin
      send_words(16, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      accept(1'b1);
      finish_block(rand_digest());
    end
    read_rd(1'b0, 4'd0, s);
    chk("t7_wrap", 512'(s[31:16]), 512'(0));
    chk("t7_done", 512'(s[7]), 512'(1));
    for (int w = 0; w < 8; w++) begin
      read_rd(1'b1, 4'(w), s);
    end
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
